// File: rtl/core_pkg.sv
// core_pkg: shared S1 instruction-fetch request/response types.
package core_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } mmu_instr_req_s;
  typedef struct packed {
    logic        ready;
    logic [31:0] instr;
    logic        illegal;
  } mmu_instr_rsp_s;
endpackage

// File: rtl/mmu_instr_line_buf.sv
// mmu_instr_line_buf: single-line instruction buffer with a beat write port and combinational hit/read.
module mmu_instr_line_buf #(
  parameter  int LINE_WORDS = 4,
  localparam int OFF_W      = $clog2(LINE_WORDS * 4),
  localparam int IDX_W      = OFF_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inval,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             commit,
  input  logic [31:OFF_W]  commit_tag,
  input  logic             commit_valid,
  input  logic             commit_err,
  input  logic [31:0]      rd_addr,
  output logic             hit,
  output logic [31:0]      rd_data,
  output logic             err
);
  logic              line_valid;
  logic              line_err;
  logic [31:OFF_W]   line_tag;
  logic [31:0]       line_data [LINE_WORDS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      line_valid <= 1'b0;
      line_err   <= 1'b0;
      line_tag   <= '0;
    end else if (commit) begin
      line_valid <= commit_valid;
      line_err   <= commit_err;
      line_tag   <= commit_tag;
    end else if (inval) begin
      line_valid <= 1'b0;
    end
  always_ff @(posedge clk)
    if (wr_en) line_data[wr_idx] <= wr_data;
  assign hit     = line_valid & (line_tag == rd_addr[31:OFF_W]);
  assign rd_data = line_data[rd_addr[OFF_W-1:2]];
  assign err     = line_err;
endmodule

// File: rtl/mmu_instr_responder.sv
// mmu_instr_responder: S1 instruction-fetch responder serving a one-line buffer, refilled
// by an in-order burst on a miss; translation is bypassed.
module mmu_instr_responder
  import core_pkg::*;
#(
  parameter  int LINE_WORDS = 4,
  localparam int OFF_W      = $clog2(LINE_WORDS * 4),
  localparam int IDX_W      = OFF_W - 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  mmu_instr_req_s mmu_instr_req,
  output mmu_instr_rsp_s mmu_instr_rsp,
  input  logic           flush,
  output logic           bus_req_valid,
  input  logic           bus_req_ready,
  output logic [31:0]    bus_req_addr,
  input  logic           bus_rsp_valid,
  input  logic [31:0]    bus_rsp_data,
  input  logic           bus_rsp_err
);
  typedef enum logic [1:0] {IDLE, BUS_REQ, FILL} state_e;
  state_e           state, state_n;
  logic [IDX_W-1:0] beat_cnt;
  logic             fill_err, fill_drop;
  logic             misal, hit, start, beat, last, buf_hit, buf_err;
  logic [31:0]      buf_data;
  assign misal = mmu_instr_req.valid & |mmu_instr_req.addr[1:0];
  assign hit   = mmu_instr_req.valid & ~misal & buf_hit & ~flush;
  assign start = (state == IDLE) & mmu_instr_req.valid & ~misal & ~buf_hit & ~flush;
  assign beat  = (state == FILL) & bus_rsp_valid;
  assign last  = beat & (beat_cnt == IDX_W'(LINE_WORDS - 1));
  always_comb
    state_n = start ? BUS_REQ :
              (state == BUS_REQ && bus_req_ready) ? FILL :
              last ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      bus_req_addr <= '0;
      beat_cnt     <= '0;
      fill_err     <= 1'b0;
      fill_drop    <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        bus_req_addr <= {mmu_instr_req.addr[31:OFF_W], {OFF_W{1'b0}}};
        fill_err     <= 1'b0;
        fill_drop    <= 1'b0;
      end
      if (state == BUS_REQ && bus_req_ready) beat_cnt <= '0;
      if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
        fill_err <= fill_err | bus_rsp_err;
      end
      // A flush during a refill cannot abort the burst; it only poisons the result.
      if (flush && state != IDLE) fill_drop <= 1'b1;
    end
  assign bus_req_valid = (state == BUS_REQ);
  mmu_instr_line_buf #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .inval        (flush | start),
    .wr_en        (beat),
    .wr_idx       (beat_cnt),
    .wr_data      (bus_rsp_data),
    .commit       (last),
    .commit_tag   (bus_req_addr[31:OFF_W]),
    .commit_valid (~(fill_drop | flush)),
    .commit_err   (fill_err | bus_rsp_err),
    .rd_addr      (mmu_instr_req.addr),
    .hit          (buf_hit),
    .rd_data      (buf_data),
    .err          (buf_err)
  );
  assign mmu_instr_rsp = '{ready:   misal | hit,
                           instr:   hit ? buf_data : 32'h0,
                           illegal: misal | (hit & buf_err)};
  assert property (@(posedge clk) disable iff (!rst_n) bus_rsp_valid |-> state == FILL);
endmodule
